// File: rtl/dclk_meter_pkg.sv
// Shared definitions for divided-clock consumers.
// Contents: FSM state encoding, default divider constants, and the
// expected-period helper 1 << (base_exp - sel).
package dclk_meter_pkg;

  localparam int unsigned SEL_W    = 3;
  localparam int unsigned BASE_EXP = 16;
  localparam int unsigned EXP_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  // Expected dclk period in clk cycles for a given divider select.
  function automatic logic [EXP_W-1:0] exp_period(input logic [7:0] sel,
                                                  input int unsigned base_exp = BASE_EXP);
    return EXP_W'(1) << (base_exp - 32'(sel));
  endfunction

endpackage

// File: rtl/dclk_edge_det.sv
// Rising-edge detector for a divided clock that is synchronous to clk_i.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   dclk_i  divided clock
//   rise_c  combinational: dclk_i high this cycle, low last cycle
module dclk_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic dclk_i,
  output logic rise_c
);

  logic dclk_q;

  // Previous-cycle copy of dclk_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dclk_q <= 1'b0;
    end else begin
      dclk_q <= dclk_i;
    end
  end

  assign rise_c = dclk_i & ~dclk_q;

endmodule

// File: rtl/dclk_period_meter.sv
// Measures the period of the divider output dclk in clk cycles and checks
// it against 2^(BASE_EXP-sel). Reports each measurement with a valid pulse
// and keeps sticky error / timeout flags until clr_i or reset.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   en_i           measurement enable
//   clr_i          clears err_o / timeout_o (a same-cycle set wins)
//   sel_i          divider select currently driven to the divider
//   dclk_i         divided clock
//   period_o       last measured period (all ones on timeout)
//   valid_o        one-cycle pulse when period_o / match_o update
//   match_o        period_o equals the expected period
//   err_o          sticky mismatch-or-timeout flag
//   timeout_o      sticky: counter saturated without a rising edge
//   busy_o         state is ARM or MEASURE
module dclk_period_meter #(
  parameter int unsigned SEL_W    = dclk_meter_pkg::SEL_W,
  parameter int unsigned BASE_EXP = dclk_meter_pkg::BASE_EXP,
  parameter int unsigned CNT_W    = 18
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             dclk_i,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             match_o,
  output logic             err_o,
  output logic             timeout_o,
  output logic             busy_o
);

  import dclk_meter_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] sel_q;
  logic             rise_c;
  logic             sel_chg_c;
  logic [CNT_W-1:0] exp_c;

  dclk_edge_det u_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .dclk_i (dclk_i),
    .rise_c (rise_c)
  );

  assign sel_chg_c = (sel_i != sel_q);
  assign exp_c     = CNT_W'(exp_period(8'(sel_q), BASE_EXP));

  // Measurement FSM; priority is en_i low, then sel change, then rise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sel_q     <= '0;
      period_o  <= '0;
      valid_o   <= 1'b0;
      match_o   <= 1'b0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      // Clear first so any set later in this block takes precedence.
      if (clr_i) begin
        err_o     <= 1'b0;
        timeout_o <= 1'b0;
      end
      if (!en_i) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        busy_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            sel_q  <= sel_i;
            cnt    <= '0;
            state  <= ST_ARM;
            busy_o <= 1'b1;
          end
          ST_ARM: begin
            // No timeout here: wait indefinitely for the first edge.
            if (sel_chg_c) begin
              sel_q <= sel_i;
            end else if (rise_c) begin
              cnt   <= CNT_ONE;
              state <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (sel_chg_c) begin
              // Abandon the partial period silently and re-arm.
              sel_q <= sel_i;
              cnt   <= '0;
              state <= ST_ARM;
            end else if (rise_c) begin
              period_o <= cnt;
              match_o  <= (cnt == exp_c);
              valid_o  <= 1'b1;
              if (cnt != exp_c) begin
                err_o <= 1'b1;
              end
              cnt <= CNT_ONE;
            end else if (cnt == CNT_MAX) begin
              period_o  <= CNT_MAX;
              match_o   <= 1'b0;
              valid_o   <= 1'b1;
              err_o     <= 1'b1;
              timeout_o <= 1'b1;
              cnt       <= '0;
              state     <= ST_ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/dclk_period_meter.md
Name: dclk_period_meter

Overview:
- Downstream consumer of the clock divider's divided-clock output `dclk`.
- Measures the `dclk` period in `clk` cycles and compares it against the expected value 2^(BASE_EXP-sel).
- Reports each measurement and flags mismatches or timeouts with a sticky error. This is the in-silicon equivalent of the bench period check.
- `dclk` is generated from a counter clocked by `clk`, so it is treated as synchronous to `clk_i`. No CDC synchroniser is used.

Parameters:
- SEL_W, 3, width of the divider select.
- BASE_EXP, 16, expected period is 2^(BASE_EXP-sel) `clk` cycles.
- CNT_W, 18, period counter width. Must satisfy 2^CNT_W-1 > 2^BASE_EXP.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  measurement enable.
- clr_i  in  1  single-cycle pulse; clears err_o and timeout_o.
- sel_i  in  SEL_W  divider select currently driven to the divider.
- dclk_i  in  1  divided clock from the divider.
- period_o  out  CNT_W  last measured period in `clk` cycles.
- valid_o  out  1  one-cycle pulse; period_o and match_o updated.
- match_o  out  1  period_o equals the expected period (held between valid pulses).
- err_o  out  1  sticky: any mismatch or timeout since reset/clr.
- timeout_o  out  1  sticky: counter saturated without a rising edge.
- busy_o  out  1  state is ARM or MEASURE.

Behaviour:
- Reset (rst_i=1, asynchronous): state=IDLE, dclk_q=0, cnt=0, sel_q=0; all outputs 0.
- Edge detect: dclk_q registers dclk_i every cycle. rise = dclk_i & ~dclk_q.
- Expected period: exp = 1 << (BASE_EXP - sel_q), computed at CNT_W width.
- FSM states: IDLE, ARM, MEASURE.
- IDLE:
  - cnt=0, busy_o=0.
  - en_i=1 → ARM; sel_q <= sel_i.
- ARM:
  - Waits for the first rise.
  - On rise: cnt <= 1 and go to MEASURE.
  - No valid_o is produced for a partial period.
- MEASURE, each cycle:
  - If rise: period_o <= cnt; match_o <= (cnt == exp); valid_o <= 1 next cycle; err_o <= err_o | (cnt != exp); cnt <= 1; stay in MEASURE (back-to-back measurements).
  - Otherwise: cnt <= cnt + 1.
- Latency: with rising edges at cycles t0 and t0+N, period_o = N and valid_o is high at cycle t0+N+1.
- Timeout: in MEASURE, if cnt == 2^CNT_W-1 and no rise:
  - timeout_o <= 1, err_o <= 1, period_o <= all ones, match_o <= 0, valid_o pulses.
  - Go to ARM; cnt <= 0.
- sel change: in ARM or MEASURE, if sel_i != sel_q:
  - sel_q <= sel_i; go to ARM.
  - No valid_o and no error for the aborted period.
  - sel change has priority over rise in the same cycle.
- en_i=0 in any state:
  - → IDLE next cycle.
  - period_o, match_o, err_o, timeout_o hold; valid_o=0.
  - Precedence: en_i=0 over sel change, then sel change over rise.
- clr_i: clears err_o and timeout_o. If the same cycle sets an error, the set wins.
- Reset mid-measurement: returns to IDLE asynchronously. The next measurement needs a fresh ARM edge.
- ARM state: timeout is not checked; the block waits indefinitely for the first edge.

Decomposition:
- Shared package or include `dclk_meter_pkg`:
  - FSM state encoding (IDLE=2'd0, ARM=2'd1, MEASURE=2'd2).
  - Constants BASE_EXP and SEL_W.
  - Function exp_period(sel) returning 1 << (BASE_EXP-sel).
- Sub-module `dclk_edge_det`: dclk_q register plus rise output. Reused by any other divided-clock consumer.

Test Plan:
All cases run a 10 ns clk_i, the real divider driving dclk_i, and en_i=1.
- Basic, sel=7: ARM, then valid_o at 513 cycles after the first rise, with period_o=512, match_o=1, err_o=0. Three consecutive valid pulses, 512 cycles apart.
- Sweep sel 0..7, each held for 3 periods: period_o = 65536, 32768, …, 512; match_o=1 throughout; err_o stays 0.
- Bench-forced dclk_i toggling with a 100-cycle period at sel=7: period_o=100, match_o=0, err_o=1. Then clr_i → err_o=0, and err_o sets again on the next valid.
- sel change 5→6 mid-period: no valid_o for the aborted period; busy_o stays 1. Next valid gives period_o=1024, match_o=1, err_o=0.
- dclk_i held 0 after arming, with CNT_W=12 override: 4095 cycles after the arming rise, timeout_o=1, err_o=1, period_o=4095, one valid_o pulse, state returns to ARM.
- rst_i asserted 3 cycles mid-MEASURE: all outputs 0 immediately (asynchronous). After release, the first valid_o arrives one full period after the first rise.
